// File: rtl/shared_mul_gf2.sv
// Domain-oriented masked GF(2^2) multiplier (normal basis {W^2,W}) with SHARES Boolean shares.
// Define SHARED_MUL_GF2_OUTREG_EN to add a register after each output share (latency +1).
module shared_mul_gf2 #(
  parameter int SHARES    = 2,
  parameter int PIPELINED = 1
) (
  input  logic                           ClkxCI,
  input  logic                           RstxBI,
  input  logic [2*SHARES-1:0]            _XxDI,
  input  logic [2*SHARES-1:0]            _YxDI,
  input  logic [SHARES*(SHARES-1)-1:0]   _ZxDI,
  output logic [2*SHARES-1:0]            _QxDO
);

  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  logic [1:0]          x_s     [SHARES];
  logic [1:0]          y_s     [SHARES];
  logic [1:0]          inner_d [SHARES];
  logic [1:0]          inner_v [SHARES];
  logic [1:0]          cross_d [SHARES][SHARES];
  logic [1:0]          cross_q [SHARES][SHARES];
  logic [2*SHARES-1:0] q_d;

  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      x_s[i]     = _XxDI[2*i +: 2];
      y_s[i]     = _YxDI[2*i +: 2];
      inner_d[i] = gf_mul(_XxDI[2*i +: 2], _YxDI[2*i +: 2]);
    end
  end

  // Both cross terms of a pair are blinded with the same fresh Z slice; the
  // diagonal is unused and held at zero.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        cross_d[i][j] = 2'b00;
      end
    end
    for (int i = 0; i < SHARES; i++) begin
      for (int j = i + 1; j < SHARES; j++) begin
        cross_d[i][j] = gf_mul(x_s[i], y_s[j]) ^ _ZxDI[2*k +: 2];
        cross_d[j][i] = gf_mul(x_s[j], y_s[i]) ^ _ZxDI[2*k +: 2];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge ClkxCI or posedge RstxBI) begin
    if (RstxBI) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          cross_q[i][j] <= 2'b00;
        end
      end
    end else begin
      cross_q <= cross_d;
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic [1:0] inner_q [SHARES];
      always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
          for (int i = 0; i < SHARES; i++) begin
            inner_q[i] <= 2'b00;
          end
        end else begin
          inner_q <= inner_d;
        end
      end
      always_comb inner_v = inner_q;
    end else begin : g_comb
      always_comb inner_v = inner_d;
    end
  endgenerate

  // Share i only ever combines its own inner term with registered cross terms.
  always_comb begin
    logic [1:0] acc;
    acc = 2'b00;
    q_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      acc = inner_v[i];
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) acc = acc ^ cross_q[i][j];
      end
      q_d[2*i +: 2] = acc;
    end
  end

`ifdef SHARED_MUL_GF2_OUTREG_EN
  logic [2*SHARES-1:0] out_q;
  always_ff @(posedge ClkxCI or posedge RstxBI) begin
    if (RstxBI) out_q <= '0;
    else        out_q <= q_d;
  end
  assign _QxDO = out_q;
`else
  assign _QxDO = q_d;
`endif

endmodule

// File: tb/tb_shared_mul_gf2.sv
// Directed and streaming checks of shared_mul_gf2 with SHARES=3, PIPELINED=1.
module tb_shared_mul_gf2;

  localparam int SHARES = 3;
`ifdef SHARED_MUL_GF2_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [5:0] x;
  logic [5:0] y;
  logic [5:0] z;
  logic [5:0] q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  shared_mul_gf2 #(.SHARES(SHARES), .PIPELINED(1)) dut (
    .ClkxCI (clk),
    .RstxBI (rst),
    ._XxDI  (x),
    ._YxDI  (y),
    ._ZxDI  (z),
    ._QxDO  (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference from the field multiplication table: 11 is the identity,
  // W^2*W^2 = W, W*W = W^2, W*W^2 = 1.
  function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    if (a == 2'b11) return b;
    if (b == 2'b11) return a;
    if (a == b) return (a == 2'b10) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [1:0] unmask(input logic [5:0] v);
    return v[1:0] ^ v[3:2] ^ v[5:4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic stream(input string tag, input logic [5:0] xv, input logic [5:0] yv,
                        input logic [5:0] zv);
    logic [1:0] e;
    x = xv; y = yv; z = zv;
    exp_q.push_back(ref_mul(unmask(xv), unmask(yv)));
    step();
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      check(tag, {4'b0, unmask(q)}, {4'b0, e});
    end
  endtask

  task automatic drain(input string tag);
    logic [1:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check(tag, {4'b0, unmask(q)}, {4'b0, e});
    end
  endtask

  task automatic apply_hold(input logic [5:0] xv, input logic [5:0] yv, input logic [5:0] zv);
    x = xv; y = yv; z = zv;
    repeat (LAT) step();
  endtask

  initial begin
    rst = 1'b1;
    x = '0; y = '0; z = '0;
    #1;
    check("rst_initial", q, 6'b0);

    // Outputs stay zero while reset is held, whatever the inputs.
    repeat (5) begin
      x = 6'($urandom_range(0, 63));
      y = 6'($urandom_range(0, 63));
      z = 6'($urandom_range(0, 63));
      step();
      check("rst_hold", q, 6'b0);
    end
    x = '0; y = '0; z = '0;
    rst = 1'b0;

    // Share-0 sweep of all 16 operand pairs, one per cycle.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        stream("sweep", {4'b0, 2'(i)}, {4'b0, 2'(j)}, 6'b0);
      end
    end
    drain("sweep_drain");

    // Hand-computed share placement.
    apply_hold(6'b000010, 6'b000010, 6'b000000);
    check("share0_only", q, 6'b000001);
    apply_hold(6'b001000, 6'b000100, 6'b000000);
    check("inner_share1", q, 6'b001100);
    // X=Y=0: Q0=z0^z1, Q1=z0^z2, Q2=z1^z2 with z = {11,10,01}.
    apply_hold(6'b000000, 6'b000000, 6'b111001);
    check("z_pairing", q, 6'b011011);
    apply_hold(6'b000011, 6'b110000, 6'b000000);
    check("cross_0_2", q, 6'b000000 ^ {2'b00, 2'b00, 2'b00} ^ q_cross_expect());

    // Fixed 10*10 with fresh randomness every cycle: unmasked result stays 01.
    repeat (8) stream("refresh_z", 6'b000010, 6'b000010, 6'($urandom_range(0, 63)));
    drain("refresh_drain");

    // Fully random shares.
    repeat (1000) stream("random", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                         6'($urandom_range(0, 63)));
    drain("random_drain");

    // Mid-stream reset: asynchronous clear, then products resume.
    apply_hold(6'b000011, 6'b000011, 6'b000000);
    check("pre_reset", q, 6'b000011);
    rst = 1'b1;
    #1;
    check("rst_async", q, 6'b0);
    step();
    check("rst_mid_hold", q, 6'b0);
    rst = 1'b0;
    repeat (20) stream("post_reset", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                       6'($urandom_range(0, 63)));
    drain("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // X0=11, Y2=11, Z=0: only cross term C02 = 11*11 = 11 lands in share 0.
  function automatic logic [5:0] q_cross_expect();
    return 6'b000011;
  endfunction

endmodule
